// File: rtl/shared_reg_arb.sv
// shared_reg_arb
//   Round-robin arbiter/sequencer sharing one loadable N-bit register among
//   four requesters. A winner is picked in IDLE, its data is captured into a
//   hold register, written to the shared register at the end of LOAD and
//   acknowledged with a one-cycle pulse in ACK. All state changes on the
//   falling edge of ck.
//
// Ports
//   ck      in   clock, falling-edge active
//   rst     in   synchronous reset, active-high
//   req     in   [3:0]    request lines, bit i = requester i
//   d       in   [4*N-1:0] requester data, requester i owns d[i*N +: N]
//   ack     out  [3:0]    one-hot ack pulse to the granted requester
//   q       out  [N-1:0]  shared register contents
//   load    out  load strobe to the shared register (high in LOAD)
//   busy    out  high in GRANT, LOAD and ACK
//   gnt_id  out  [1:0]    index of the current or most recent grant
module shared_reg_arb #(
  parameter int N = 4
) (
  input  logic           ck,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*N-1:0] d,
  output logic [3:0]     ack,
  output logic [N-1:0]   q,
  output logic           load,
  output logic           busy,
  output logic [1:0]     gnt_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOAD  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [1:0]     ptr;
  logic [N-1:0]   hold;
  logic [1:0]     winner;

  // First set request bit searching ptr, ptr+1, ... mod 4. The search runs
  // from the farthest offset down so the nearest set bit is the last write.
  function automatic logic [1:0] pick_winner(input logic [3:0] r,
                                             input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] w;
    w = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  assign winner = pick_winner(req, ptr);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = GRANT;
      GRANT:   state_nxt = LOAD;
      LOAD:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge ck) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 2'd0;
      gnt_id <= 2'd0;
      hold   <= '0;
      q      <= '0;
    end else begin
      state <= state_nxt;
      // Data is captured only here; later changes on d/req are ignored.
      if (state == IDLE && |req) begin
        gnt_id <= winner;
        hold   <= d[int'(winner)*N +: N];
      end
      if (state == LOAD) q <= hold;
      if (state == ACK) ptr <= gnt_id + 2'd1;
    end
  end

  // Outputs decode registered state only; req has no path to them.
  always_comb begin
    ack = 4'b0000;
    if (state == ACK) ack[gnt_id] = 1'b1;
  end

  assign load = (state == LOAD);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_shared_reg_arb.sv
module tb_shared_reg_arb;

  localparam int N = 4;

  logic           ck;
  logic           rst;
  logic [3:0]     req;
  logic [4*N-1:0] d;
  logic [3:0]     ack;
  logic [N-1:0]   q;
  logic           load;
  logic           busy;
  logic [1:0]     gnt_id;

  int checks;
  int errors;

  shared_reg_arb #(.N(N)) dut (
    .ck     (ck),
    .rst    (rst),
    .req    (req),
    .d      (d),
    .ack    (ack),
    .q      (q),
    .load   (load),
    .busy   (busy),
    .gnt_id (gnt_id)
  );

  initial begin
    ck = 1'b1;
    forever #5 ck = ~ck;
  end

  // DUT acts on negedge; the bench samples and drives on posedge.
  task automatic tick();
    @(posedge ck);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1;
    req = 4'b1111;
    d   = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (q !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: q=%b ack=%b busy=%b gnt=%b, want q=0000 ack=0000 busy=0 gnt=00",
                 i, q, ack, busy, gnt_id);
      end
    end
    rst = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (ack !== 4'b0001 || gnt_id !== 2'd0 || q !== 4'b1111) begin
      errors++;
      $display("FAIL reset_first_grant: ack=%b gnt=%0d q=%b, want ack=0001 gnt=0 q=1111", ack, gnt_id, q);
    end
    req = 4'b0000;
  endtask

  task automatic test_single();
    do_reset();
    d   = 16'h0000;
    d[1*N +: N] = 4'b0101;
    req = 4'b0010;
    tick(); // GRANT
    checks++;
    if (busy !== 1'b1 || load !== 1'b0 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_grant: busy=%b load=%b ack=%b, want 1 0 0000", busy, load, ack);
    end
    tick(); // LOAD
    checks++;
    if (busy !== 1'b1 || load !== 1'b1 || ack !== 4'b0000 || q !== 4'b0000) begin
      errors++;
      $display("FAIL single_load: busy=%b load=%b ack=%b q=%b, want 1 1 0000 0000", busy, load, ack, q);
    end
    tick(); // ACK
    checks++;
    if (busy !== 1'b1 || load !== 1'b0 || ack !== 4'b0010 || q !== 4'b0101 || gnt_id !== 2'd1) begin
      errors++;
      $display("FAIL single_ack: busy=%b load=%b ack=%b q=%b gnt=%0d, want 1 0 0010 0101 1",
               busy, load, ack, q, gnt_id);
    end
    req = 4'b0000;
    tick(); // IDLE
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0000 || q !== 4'b0101 || gnt_id !== 2'd1) begin
      errors++;
      $display("FAIL single_idle: busy=%b ack=%b q=%b gnt=%0d, want 0 0000 0101 1", busy, ack, q, gnt_id);
    end
  endtask

  task automatic test_all_four();
    logic [1:0] exp_g [5];
    logic [3:0] exp_q [5];
    int k;
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_q = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0001};
    do_reset();
    d   = 16'h4321;
    req = 4'b1111;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i % 4 == 2) begin
        checks++;
        if (ack !== (4'b0001 << exp_g[k]) || gnt_id !== exp_g[k] || q !== exp_q[k]) begin
          errors++;
          $display("FAIL all4_grant%0d: ack=%b gnt=%0d q=%b, want gnt=%0d q=%b",
                   k, ack, gnt_id, q, exp_g[k], exp_q[k]);
        end
        k++;
      end else if (i % 4 == 0) begin
        checks++;
        if (ack !== 4'b0000) begin
          errors++;
          $display("FAIL all4_noack cyc%0d: ack=%b, want 0000", i, ack);
        end
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_wrap();
    logic [1:0] exp_g [4];
    exp_g = '{2'd0, 2'd3, 2'd0, 2'd3};
    do_reset();
    d = 16'h8001;
    req = 4'b1000;
    tick(); tick(); tick();
    checks++;
    if (ack !== 4'b1000 || gnt_id !== 2'd3) begin
      errors++;
      $display("FAIL wrap_first: ack=%b gnt=%0d, want 1000 3", ack, gnt_id);
    end
    req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick(); tick(); tick(); tick();
      checks++;
      if (ack !== (4'b0001 << exp_g[i]) || gnt_id !== exp_g[i]
          || q !== (exp_g[i] == 2'd0 ? 4'b0001 : 4'b1000)) begin
        errors++;
        $display("FAIL wrap_grant%0d: ack=%b gnt=%0d q=%b, want gnt=%0d", i, ack, gnt_id, q, exp_g[i]);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_mid_change();
    do_reset();
    d = 16'h0000;
    d[2*N +: N] = 4'b1010;
    req = 4'b0100;
    tick(); // GRANT
    req = 4'b0000;
    d[2*N +: N] = 4'b1111;
    tick(); tick(); // ACK
    checks++;
    if (ack !== 4'b0100 || q !== 4'b1010) begin
      errors++;
      $display("FAIL midchg_ack: ack=%b q=%b, want 0100 1010", ack, q);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || ack !== 4'b0000 || q !== 4'b1010) begin
        errors++;
        $display("FAIL midchg_idle cyc%0d: busy=%b ack=%b q=%b, want 0 0000 1010", i, busy, ack, q);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d = 16'h0000;
    d[0 +: N] = 4'b0110;
    req = 4'b0001;
    tick(); // GRANT
    req = 4'b0000;
    tick(); // LOAD
    checks++;
    if (load !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_load: load=%b, want 1", load);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (q !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_abort: q=%b ack=%b busy=%b gnt=%0d, want 0000 0000 0 0", q, ack, busy, gnt_id);
    end
    tick();
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_noack: ack=%b busy=%b, want 0000 0", ack, busy);
    end
    // Two requesters: ptr must be 0 after reset, so requester 0 wins.
    d[1*N +: N] = 4'b1001;
    req = 4'b0011;
    tick(); tick(); tick();
    checks++;
    if (ack !== 4'b0001 || q !== 4'b0110 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_resume: ack=%b q=%b gnt=%0d, want 0001 0110 0", ack, q, gnt_id);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    req = 4'b0000;
    d   = '0;
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_mid_change();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shared_reg_arb.md
Name: shared_reg_arb

Overview:
- Round-robin arbiter and sequencer that shares one loadable N-bit register among four requesters.
- Each requester presents write data with a req/ack handshake. The block grants one requester at a time, drives the register's load, and returns a one-cycle ack.
- Sits between requesting units and the shared register. The register is instantiated inside this block and its contents are exported on q.

Parameters:
- N, 4, width of the shared register and of each requester data bus.

Ports:
- ck  input  1  clock; all state updates on the falling edge of ck.
- rst  input  1  synchronous reset, active-high, sampled on the falling edge of ck.
- req  input  4  request lines, bit i = requester i.
- d  input  4*N  requester data, flat bus; requester i owns d[i*N +: N].
- ack  output  4  one-hot ack pulse to the granted requester.
- q  output  N  shared register contents.
- load  output  1  load strobe to the internal register, high during LOAD.
- busy  output  1  high while state is not IDLE.
- gnt_id  output  2  index of the current or most recent grant.

Behaviour:
- Reset (rst=1 at a falling edge):
  - state=IDLE, q=0, ack=0000, load=0, busy=0, gnt_id=00.
  - Priority pointer ptr=0, hold register=0.
  - Reset has priority over every other event, including mid-transaction. A transaction aborted by reset produces no ack and no q update, unless q was already written at an earlier edge; reset then clears q to 0 anyway.
- States: IDLE, GRANT, LOAD, ACK. Outputs are decoded from registered state and registers only; no combinational path from req to outputs.
- IDLE:
  - If req==0000, stay.
  - Else select the winner: the first set bit searching ptr, ptr+1, ... mod 4.
  - At that edge latch gnt_id=winner and hold=d[winner], then go to GRANT.
- GRANT: unconditional transition to LOAD.
- LOAD:
  - load=1.
  - At the edge ending LOAD, q<=hold; go to ACK.
- ACK:
  - ack[gnt_id]=1, all other ack bits 0.
  - At the edge ending ACK, ptr<=(gnt_id+1) mod 4; go to IDLE.
- Latency: req sampled at edge k → q updated at edge k+2 → ack high between edges k+2 and k+3 → IDLE from edge k+3 → next request sampled at edge k+4. Minimum 4 cycles per transaction.
- Data is captured only at the IDLE→GRANT edge. Changes to d or req after that edge do not affect the transaction.
- A requester dropping req mid-transaction does not cancel it; ack is still pulsed.
- A requester must drop req no later than the edge ending ACK. A req still high when IDLE samples counts as a new request.
- Simultaneous requests are resolved only by ptr. Pointer wrap: after a grant to 3, ptr=0.
- q holds its value in all states except the LOAD exit edge.
- gnt_id holds its value in IDLE.
- busy=1 in GRANT, LOAD and ACK.

Test Plan (all with N=4):
- Reset: rst=1 for 2 cycles, with req=1111 and d=all 1s → q=0000, ack=0000, busy=0, gnt_id=00 throughout; after rst=0, first grant goes to requester 0.
- Single request: req=0010, d1=0101, held until ack → busy high for 3 cycles, load high in cycle 2, q=0101 at edge k+2, ack=0010 for exactly one cycle, gnt_id=01.
- All four requests with persistent req=1111 and d0..d3=0001,0010,0011,0100 → grant order 0,1,2,3,0; q sequence 0001,0010,0011,0100,0001; consecutive acks 4 cycles apart.
- Wrap and fairness: after a grant to 3, req=1001 held → grants alternate 0,3,0,3; neither requester starves.
- Mid-transaction change: req=0100, d2=1010; in GRANT drop req2 and set d2=1111 → q=1010, ack=0100 still pulses, IDLE afterwards with no further grant.
- Reset mid-operation: assert rst for one cycle during LOAD of a request with d0=0110 → q=0000, no ack pulse, state IDLE, ptr=0; subsequent req=0001 completes normally.
